// File: rtl/fetch_stage.sv
// IF stage: PC register driving a combinational IMem, 1-cycle capture into IF/ID; Stall holds PC and IF/ID.
// RedirectEX and ID-stage J/JAL squash the wrong-path fetch; perf counters under FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        RedirectEX,
  input  logic [31:0] RedirectPC,
  output logic [31:0] IMemAddress,
  input  logic [31:0] IMemInstruction,
  output logic [31:0] Instruction_ID,
  output logic [31:0] PCPlus4_ID,
  output logic        Valid_ID
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] StallCount
`endif
);

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pcplus4;
  } ifid_t;

  // All-zero bubble decodes as sll $0,$0,0, harmless even if valid is ignored.
  localparam ifid_t       BUBBLE           = '0;
  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_nxt;
  logic [31:0] jump_target;
  logic        jump_id;
  ifid_t       ifid;
  ifid_t       ifid_nxt;

  assign IMemAddress    = pc;
  assign pc_plus4       = pc + 32'd4;
  assign Instruction_ID = ifid.instr;
  assign PCPlus4_ID     = ifid.pcplus4;
  assign Valid_ID       = ifid.valid;

  assign jump_id     = ifid.valid & ((ifid.instr[31:26] == 6'h02) | (ifid.instr[31:26] == 6'h03));
  assign jump_target = {ifid.pcplus4[31:28], ifid.instr[25:0], 2'b00};

  always_comb begin
    pc_nxt   = pc_plus4;
    ifid_nxt = '{valid: 1'b1, instr: IMemInstruction, pcplus4: pc_plus4};
    if (RedirectEX) begin
      pc_nxt   = RedirectPC & 32'hFFFF_FFFC;
      ifid_nxt = BUBBLE;
    end else if (Stall) begin
      pc_nxt   = pc;
      ifid_nxt = ifid;
    end else if (jump_id) begin
      // No delay slot: the sequential fetch behind the jump is dropped.
      pc_nxt   = jump_target;
      ifid_nxt = BUBBLE;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc   <= RESET_PC_ALIGNED;
      ifid <= BUBBLE;
    end else begin
      pc   <= pc_nxt;
      ifid <= ifid_nxt;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic fetch_fire;
  logic stall_hit;

  assign fetch_fire = ~RedirectEX & ~Stall & ~jump_id;
  assign stall_hit  = Stall & ~RedirectEX;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      FetchCount <= '0;
      StallCount <= '0;
    end else begin
      if (fetch_fire) FetchCount <= FetchCount + 32'd1;
      if (stall_hit)  StallCount <= StallCount + 32'd1;
    end
  end
`endif

endmodule
